// File: rtl/mem_responder_pkg.sv
// Shared CPU-side memory definitions: responder FSM state encodings and
// default handshake latencies.
package mem_responder_pkg;

    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StReq  = 4'b0010,
        StRsp  = 4'b0100,
        StVld  = 4'b1000
    } mem_state_e;

    localparam int unsigned DefaultReqLat  = 1;
    localparam int unsigned DefaultRespLat = 1;
    localparam int unsigned CntW           = 4;

endpackage

// File: rtl/mem_sram_1rw.sv
// Single-port word storage with byte write enables, synchronous write and
// combinational read. Contents are deliberately not reset.
module mem_sram_1rw #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic                           we,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     wstrb,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: request acceptance after REQ_LAT cycles, read response
// presented RESP_LAT cycles after the read handshake, held until taken.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned REQ_LAT     = DefaultReqLat,
    parameter int unsigned RESP_LAT    = DefaultRespLat
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     sram_rdata;
    logic [AW-1:0]   index;
    logic            req;
    logic            we;
    logic            unused_addr;

    // Byte offset is ignored and bits above the index wrap silently.
    assign index       = Address[AW+1:2];
    assign unused_addr = ^{Address[31:AW+2], Address[1:0]};
    assign req         = MemRead | MemWrite;
    assign Read_data   = rdata_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rdata_d         = rdata_q;
        Mem_Req_Ready   = 1'b0;
        Read_data_Valid = 1'b0;
        we              = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    cnt_d   = CntW'(REQ_LAT);
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    // Reset wins over a handshake in the same cycle.
                    Mem_Req_Ready = !rst;
                    if (MemWrite) begin
                        we      = !rst;
                        state_d = StIdle;
                    end else begin
                        rdata_d = sram_rdata;
                        cnt_d   = CntW'(RESP_LAT - 1);
                        state_d = StRsp;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRsp: begin
                if (cnt_q == '0) begin
                    state_d = StVld;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StVld: begin
                Read_data_Valid = 1'b1;
                if (Read_data_Ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    mem_sram_1rw #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk  (clk),
        .addr (index),
        .we   (we),
        .wdata(Write_data),
        .wstrb(Write_strb),
        .rdata(sram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table of writes/reads plus
// hand-written hold, withdraw, dual-request and mid-response reset sequences.
module tb_mem_responder;

    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned REQ_LAT  = 2;
    localparam int unsigned RESP_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .REQ_LAT    (REQ_LAT),
        .RESP_LAT   (RESP_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .Address        (Address),
        .MemWrite       (MemWrite),
        .Write_data     (Write_data),
        .Write_strb     (Write_strb),
        .MemRead        (MemRead),
        .Mem_Req_Ready  (Mem_Req_Ready),
        .Read_data      (Read_data),
        .Read_data_Valid(Read_data_Valid),
        .Read_data_Ready(Read_data_Ready)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Counts negedges from the assertion cycle until Mem_Req_Ready is seen.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!Mem_Req_Ready && cyc < 40);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic also_read);
        int  cyc;
        logic seen_valid;
        @(negedge clk);
        Address    = a;
        Write_data = d;
        Write_strb = s;
        MemWrite   = 1'b1;
        MemRead    = also_read;
        wait_ready(cyc);
        check("wr_req_latency", 32'(cyc), 32'(REQ_LAT + 1));
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        check("wr_ready_drops", 32'(Mem_Req_Ready), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < RESP_LAT + 2; i++) begin
            seen_valid |= Read_data_Valid;
            @(negedge clk);
        end
        check("wr_no_response", 32'(seen_valid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        int cyc;
        int k;
        @(negedge clk);
        Address         = a;
        MemRead         = 1'b1;
        Read_data_Ready = 1'b1;
        wait_ready(cyc);
        check("rd_req_latency", 32'(cyc), 32'(REQ_LAT + 1));
        @(negedge clk);
        MemRead = 1'b0;
        k = 1;
        while (!Read_data_Valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        // Valid rises at handshake edge + RESP_LAT, seen on the following negedge.
        check("rd_rsp_latency", 32'(k), 32'(RESP_LAT + 1));
        check("rd_data", Read_data, exp);
        @(negedge clk);
        check("rd_valid_one_cycle", 32'(Read_data_Valid), 32'd0);
        check("rd_data_retained", Read_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int k;
        logic seen;

        vecs[0]  = '{1'b1, 32'h10,   32'hAABBCCDD, 4'b1111, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'b0000, 32'hAABBCCDD};
        vecs[2]  = '{1'b1, 32'h10,   32'h11223344, 4'b0101, 32'h0};
        vecs[3]  = '{1'b0, 32'h10,   32'h0,        4'b0000, 32'hAA22CC44};
        vecs[4]  = '{1'b1, 32'h1000, 32'h00000005, 4'b1111, 32'h0};
        vecs[5]  = '{1'b0, 32'h0,    32'h0,        4'b0000, 32'h00000005};
        vecs[6]  = '{1'b0, 32'h13,   32'h0,        4'b0000, 32'hAA22CC44};
        vecs[7]  = '{1'b1, 32'h40,   32'h12345678, 4'b1111, 32'h0};
        vecs[8]  = '{1'b1, 32'h40,   32'h0000009A, 4'b0001, 32'h0};
        vecs[9]  = '{1'b0, 32'h40,   32'h0,        4'b0000, 32'h1234569A};
        vecs[10] = '{1'b1, 32'hFFC,  32'h01020304, 4'b1111, 32'h0};
        vecs[11] = '{1'b0, 32'h1FFC, 32'h0,        4'b0000, 32'h01020304};

        rst             = 1'b1;
        Address         = '0;
        MemWrite        = 1'b0;
        Write_data      = '0;
        Write_strb      = '0;
        MemRead         = 1'b0;
        Read_data_Ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(Mem_Req_Ready), 32'd0);
        check("rst_valid", 32'(Read_data_Valid), 32'd0);
        check("rst_data", Read_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b0);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp);
            end
        end

        // Response held while not taken; a concurrent new read is refused.
        @(negedge clk);
        Address         = 32'h10;
        MemRead         = 1'b1;
        Read_data_Ready = 1'b0;
        wait_ready(cyc);
        @(negedge clk);
        k = 0;
        while (!Read_data_Valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(Read_data_Valid), 32'd1);
            check("hold_data", Read_data, 32'hAA22CC44);
            check("hold_no_accept", 32'(Mem_Req_Ready), 32'd0);
            @(negedge clk);
        end
        Read_data_Ready = 1'b1;
        @(negedge clk);
        MemRead = 1'b0;
        check("hold_released", 32'(Read_data_Valid), 32'd0);

        // Withdrawn write must not touch memory.
        @(negedge clk);
        Address    = 32'h40;
        Write_data = 32'hDEADBEEF;
        Write_strb = 4'b1111;
        MemWrite   = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        @(negedge clk);
        check("withdraw_no_ready", 32'(Mem_Req_Ready), 32'd0);
        do_read(32'h40, 32'h1234569A);

        // Read and write together act as a write with no response.
        do_write(32'h80, 32'h0BADF00D, 4'b1111, 1'b1);
        do_read(32'h80, 32'h0BADF00D);

        // Reset during the response countdown aborts the read.
        @(negedge clk);
        Address = 32'h10;
        MemRead = 1'b1;
        wait_ready(cyc);
        @(negedge clk);
        MemRead = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rsp_rst_valid", 32'(Read_data_Valid), 32'd0);
        check("rsp_rst_data", Read_data, 32'd0);
        check("rsp_rst_ready", 32'(Mem_Req_Ready), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < RESP_LAT + 2; i++) begin
            seen |= Read_data_Valid;
            @(negedge clk);
        end
        check("rsp_rst_aborted", 32'(seen), 32'd0);
        do_read(32'h10, 32'hAA22CC44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
